// File: rtl/saph_pixresp_fb.sv
// saph_pixresp_fb: answers {trigger,x,y} pixel requests with ARGB8888 pixels
// fetched from an RGB565 framebuffer, with a single-word hit cache.
// Ports: clk, rst (sync, active-high); request d_trig/d_x/d_y/d_ready;
// response q_valid/q_res; config fb_base/fb_stride/fb_width/fb_height,
// border_col, inval; memory mem_req/mem_addr/mem_ack/mem_rdata.
// Optional macro SAPH_PIXRESP_TESTPAT_EN: out-of-range pixels return a
// checkerboard instead of border_col.
module saph_pixresp_fb #(
    parameter int unsigned XW = 11,
    parameter int unsigned YW = 10,
    parameter int unsigned AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_trig,
    input  logic [XW-1:0] d_x,
    input  logic [YW-1:0] d_y,
    output logic          d_ready,
    output logic          q_valid,
    output logic [31:0]   q_res,
    input  logic [AW-1:0] fb_base,
    input  logic [AW-1:0] fb_stride,
    input  logic [XW-1:0] fb_width,
    input  logic [YW-1:0] fb_height,
    input  logic [31:0]   border_col,
    input  logic          inval,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          x0_q, x0_d;
    logic          oor_q, oor_d;
    logic [31:0]   word_q, word_d;
    logic          q_valid_q, q_valid_d;
    logic [31:0]   q_res_q, q_res_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   c_data_q, c_data_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic          c_vld_q, c_vld_d;
    logic          inv_seen_q, inv_seen_d;

    logic [AW-1:0] row_off;
    logic [AW-1:0] addr_w;
    logic          oor_w;
    logic          hit_w;
    logic [31:0]   oor_word;
    logic [15:0]   pix;
    logic [31:0]   argb;

    // Word address wraps modulo 2^AW.
    assign row_off = AW'(d_y) * fb_stride;
    assign addr_w  = fb_base + row_off + AW'(d_x >> 1);
    assign oor_w   = (d_x >= fb_width) || (d_y >= fb_height);
    // A concurrent invalidate forces a miss.
    assign hit_w   = c_vld_q && !inval && (c_addr_q == addr_w);

`ifdef SAPH_PIXRESP_TESTPAT_EN
    logic unused_border;
    assign unused_border = ^border_col;
    assign oor_word = (d_x[3] ^ d_y[3]) ? 32'hffffffff : 32'hff000000;
`else
    assign oor_word = border_col;
`endif

    // RGB565 to ARGB8888 by replicating the channel MSBs into the LSBs.
    assign pix  = x0_q ? word_q[31:16] : word_q[15:0];
    assign argb = {8'hff,
                   pix[15:11], pix[15:13],
                   pix[10:5],  pix[10:9],
                   pix[4:0],   pix[4:2]};

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        oor_d      = oor_q;
        word_d     = word_q;
        q_valid_d  = 1'b0;
        q_res_d    = q_res_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        c_data_d   = c_data_q;
        c_addr_d   = c_addr_q;
        c_vld_d    = c_vld_q & ~inval;
        inv_seen_d = inv_seen_q;
        case (state_q)
            S_IDLE: begin
                if (d_trig) begin
                    x0_d = d_x[0];
                    if (oor_w) begin
                        oor_d   = 1'b1;
                        word_d  = oor_word;
                        state_d = S_RESP;
                    end else if (hit_w) begin
                        oor_d   = 1'b0;
                        word_d  = c_data_q;
                        state_d = S_RESP;
                    end else begin
                        oor_d      = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_w;
                        inv_seen_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (inval) inv_seen_d = 1'b1;
                if (mem_ack) begin
                    word_d    = mem_rdata;
                    c_data_d  = mem_rdata;
                    c_addr_d  = mem_addr_q;
                    // Data invalidated while in flight is returned, not kept.
                    c_vld_d   = !(inval || inv_seen_q);
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                q_valid_d = 1'b1;
                q_res_d   = oor_q ? word_q : argb;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x0_q       <= 1'b0;
            oor_q      <= 1'b0;
            word_q     <= '0;
            q_valid_q  <= 1'b0;
            q_res_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            c_data_q   <= '0;
            c_addr_q   <= '0;
            c_vld_q    <= 1'b0;
            inv_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            oor_q      <= oor_d;
            word_q     <= word_d;
            q_valid_q  <= q_valid_d;
            q_res_q    <= q_res_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            c_data_q   <= c_data_d;
            c_addr_q   <= c_addr_d;
            c_vld_q    <= c_vld_d;
            inv_seen_q <= inv_seen_d;
        end
    end

    assign d_ready  = (state_q == S_IDLE);
    assign q_valid  = q_valid_q;
    assign q_res    = q_res_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: doc/saph_pixresp_fb.md
Name: saph_pixresp_fb

Overview:
- Responder end of the pixel read port. The video generator issues pixel requests as {trigger, x, y}. This block answers each one with an ARGB8888 pixel.
- Pixels are fetched from an RGB565 framebuffer in external memory through a simple request/acknowledge read port.
- A single-word hit cache means the second pixel of each 32-bit word needs no memory access.
- Sits between the video generator and the memory arbiter.

Parameters:
- XW, 11, width of the pixel x coordinate.
- YW, 10, width of the pixel y coordinate.
- AW, 24, width of the memory word address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- d_trig  in  1  pixel request strobe.
- d_x  in  XW  requested x.
- d_y  in  YW  requested y.
- d_ready  out  1  block can accept a request this cycle.
- q_valid  out  1  q_res carries the answer (one-cycle pulse).
- q_res  out  32  pixel, {A[31:24], R[23:16], G[15:8], B[7:0]}.
- fb_base  in  AW  framebuffer word address of pixel (0,0).
- fb_stride  in  AW  words per line.
- fb_width  in  XW  visible width in pixels.
- fb_height  in  YW  visible height in lines.
- border_col  in  32  colour returned for out-of-range pixels.
- inval  in  1  invalidate the hit cache.
- mem_req  out  1  memory read request.
- mem_addr  out  AW  word address.
- mem_ack  in  1  read data returned.
- mem_rdata  in  32  word: pixel 0 in [15:0], pixel 1 in [31:16].

Behaviour:
- Reset values: d_ready=1, q_valid=0, q_res=0, mem_req=0, mem_addr=0, cache invalid, state IDLE.
- State IDLE:
  - d_ready=1.
  - On d_trig, latch x, y and compute the word address fb_base + d_y*fb_stride + (d_x>>1). Arithmetic is modulo 2^AW and wraps silently.
  - Out of range (d_x>=fb_width or d_y>=fb_height) -> go to RESP with border_col; no memory access.
  - Cache hit (valid and address equal) -> go to RESP with the cached word.
  - Otherwise -> go to FETCH, with mem_req=1 and mem_addr set.
- State FETCH:
  - d_ready=0.
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack: capture mem_rdata into the cache, mark it valid, record the address, drop mem_req the same edge, go to RESP.
  - mem_ack while not requesting is ignored.
- State RESP:
  - d_ready=0.
  - q_valid=1 for exactly one cycle.
  - Pixel select is x[0].
  - RGB565 -> 8-bit per channel by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}, alpha=8'hff.
  - Returns to IDLE the next cycle.
- Latency from d_trig to q_valid:
  - Hit or out-of-range: 2 cycles (IDLE edge, then RESP).
  - Miss: 2 + cycles waited for mem_ack.
- d_trig while d_ready=0 is ignored; the requester must hold or reissue it.
- q_res holds its last value between pulses.
- inval:
  - Clears the cache valid bit at the next edge in any state.
  - If asserted in FETCH, the fetched data is still returned but not cached.
  - inval and a hit lookup in the same IDLE cycle: treated as a miss.
- fb_* inputs are sampled only in IDLE on d_trig and must be stable otherwise.
- Reset mid-FETCH: mem_req drops immediately, the outstanding ack is not awaited, and a later stray mem_ack is ignored.

Optional Feature:
- Macro SAPH_PIXRESP_TESTPAT_EN.
- Defined: out-of-range pixels return a checkerboard instead of border_col.
  - (x[3]^y[3]) ? 32'hffffffff : 32'hff000000
  - In-range behaviour is unchanged.
- Undefined: border_col is returned, and the checker logic is absent.

Test Plan:
- Setup: fb_base=0x1000, stride=400, width=800, height=600.
- Miss: request (0,0), mem_ack 3 cycles after mem_req, mem_rdata=0x07E0F800 -> mem_addr=0x1000; q_res=0xffff0000, 5 cycles after d_trig; d_ready low throughout.
- Hit: immediately request (1,0) -> no mem_req; q_res=0xff00ff00, 2 cycles after d_trig.
- Row addressing: request (5,2) -> mem_addr=0x1000+800+2=0x1322.
- Out of range, macro off:
  - border_col=0xff123456, request (800,0) -> q_res=0xff123456, no mem_req.
  - With macro on, (8,0) out-of-range via width=8 -> 0xffffffff.
- Invalidate: pulse inval, then repeat (1,0) -> a new mem_req to 0x1000 is issued.
- Reset mid-fetch: assert rst while mem_req=1 -> next cycle mem_req=0, d_ready=1, q_valid=0; a later mem_ack causes no q_valid.
